cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0_pkg.sv | 18 +
 rtl/cp0.sv | 87 ++++++++
 tb/tb_cp0.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes and the processor ID.
// Imported by the CP0 block and by anything that decodes mfc0/mtc0 or raises exceptions.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] PRID_VALUE = 32'h0000_3000;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception arbitration, mfc0/mtc0 access.
// Only the architecturally meaningful fields are stored; every other bit reads as zero.
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC_M,
  input  logic        DelaySlot_M,
  input  logic [4:0]  Exccode_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC_out,
  output logic [31:0] DOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // EXL masks both sources, so a handler cannot be re-entered before eret.
  assign int_pend = (|(HWInt & im)) & ie & ~exl;
  assign exc_pend = (Exccode_M != 5'd0) & ~exl;
  assign IntReq   = int_pend | exc_pend;

  assign sr_word    = {16'b0, im, 8'b0, exl, ie};
  assign cause_word = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
  assign EPC_out    = epc;

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc;
      REG_PRID:  DOut = PRID_VALUE;
      default:   DOut = 32'd0;
    endcase
  end

  // A taken request owns the cycle; any mtc0 or eret in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl      <= 1'b1;
        bd       <= DelaySlot_M;
        exc_code <= int_pend ? EXC_INT : Exccode_M;
        epc      <= DelaySlot_M ? (PC_M - 32'd4) : PC_M;
      end else begin
        if (WE && (A2 == REG_SR)) begin
          im  <= DIn[15:10];
          ie  <= DIn[0];
          exl <= EXLClr ? 1'b0 : DIn[1];
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (WE && (A2 == REG_EPC)) begin
          epc <= DIn;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios followed by random traffic,
// compared every cycle against a word-level model of SR/Cause/EPC.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC_M;
  logic        DelaySlot_M;
  logic [4:0]  Exccode_M;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  int checks;
  int fails;

  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  logic [31:0] last_dout;
  logic        last_int;

  cp0 dut (
    .clk(clk),
    .reset(reset),
    .A1(A1),
    .A2(A2),
    .DIn(DIn),
    .WE(WE),
    .PC_M(PC_M),
    .DelaySlot_M(DelaySlot_M),
    .Exccode_M(Exccode_M),
    .HWInt(HWInt),
    .EXLClr(EXLClr),
    .IntReq(IntReq),
    .EPC_out(EPC_out),
    .DOut(DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_3000;
      default: return 32'd0;
    endcase
  endfunction

  // One cycle: drive inputs, check combinational outputs against the model, clock, advance the model.
  task automatic applyStimulus(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] din, input logic we, input logic [31:0] pc,
                               input logic ds, input logic [4:0] exc, input logic [5:0] hw,
                               input logic clr);
    logic        ipend;
    logic        req;
    logic [31:0] n_sr;
    logic [31:0] n_cause;
    logic [31:0] n_epc;
    reset = r; A1 = a1; A2 = a2; DIn = din; WE = we; PC_M = pc;
    DelaySlot_M = ds; Exccode_M = exc; HWInt = hw; EXLClr = clr;
    #1;
    ipend = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    req   = ipend || ((exc != 5'd0) && !m_sr[1]);
    last_dout = DOut;
    last_int  = IntReq;
    if (!r) begin
      checkOutput("intreq", {31'd0, IntReq}, {31'd0, req});
      checkOutput("dout", DOut, modelRead(a1));
      checkOutput("epc_out", EPC_out, m_epc);
    end
    n_sr = m_sr; n_epc = m_epc;
    n_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
    if (r) begin
      n_sr = 0; n_cause = 0; n_epc = 0;
    end else if (req) begin
      n_sr    = m_sr | 32'h2;
      n_cause = (32'(ds) << 31) | (32'(hw) << 10) | (32'(ipend ? 5'd0 : exc) << 2);
      n_epc   = ds ? pc - 32'd4 : pc;
    end else begin
      if (we && a2 == 5'd12) n_sr = din & 32'h0000_FC03;
      if (clr) n_sr = n_sr & ~32'h2;
      if (we && a2 == 5'd14) n_epc = din;
    end
    @(posedge clk);
    #1;
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
  endtask

  initial begin
    checks = 0; fails = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b1; A1 = 0; A2 = 0; DIn = 0; WE = 0; PC_M = 0;
    DelaySlot_M = 0; Exccode_M = 0; HWInt = 0; EXLClr = 0;

    // Reset and register readback.
    applyStimulus(1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_sr", last_dout, 32'd0);
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_cause", last_dout, 32'd0);
    applyStimulus(0, 14, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_epc", last_dout, 32'd0);
    applyStimulus(0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("prid", last_dout, 32'h0000_3000);

    // Enable interrupts, then raise HWInt[2].
    applyStimulus(0, 12, 12, 32'h0000_FC01, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0000_1000, 0, 0, 6'b000100, 0);
    checkOutput("int_taken", {31'd0, last_int}, 32'd1);
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0, 6'b000100, 0);
    checkOutput("int_cause", last_dout, 32'h0000_1000);
    applyStimulus(0, 12, 0, 0, 0, 0, 0, 0, 6'b000100, 0);
    checkOutput("int_sr_exl", last_dout, 32'h0000_FC03);
    applyStimulus(0, 14, 0, 0, 0, 0, 0, 0, 6'b000100, 0);
    checkOutput("int_epc", last_dout, 32'h0000_1000);

    // EXL masks everything until eret clears it.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 10, 6'b000100, 0);
    checkOutput("exl_mask", {31'd0, last_int}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'b000100, 1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0000_2000, 0, 0, 6'b000100, 0);
    checkOutput("int_reassert", {31'd0, last_int}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Overflow in a delay slot.
    applyStimulus(0, 0, 0, 0, 0, 32'h0000_3010, 1, 12, 0, 0);
    checkOutput("ov_taken", {31'd0, last_int}, 32'd1);
    applyStimulus(0, 14, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ov_epc", last_dout, 32'h0000_300C);
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ov_cause", last_dout, 32'h8000_0030);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Exception beats a same-cycle mtc0 to EPC.
    applyStimulus(0, 0, 14, 32'h1234_5678, 1, 32'h0000_4000, 0, 5, 0, 0);
    applyStimulus(0, 14, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("exc_vs_mtc0", last_dout, 32'h0000_4000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Interrupt outranks AdEL; IP keeps tracking while EXL=1.
    applyStimulus(0, 0, 0, 0, 0, 32'h0000_5000, 0, 4, 6'b000100, 0);
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0, 6'b100000, 0);
    checkOutput("prio_cause", last_dout, 32'h0000_1000);
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
    checkOutput("ip_track", last_dout, 32'h0000_8000);

    // Reset wins over a pending exception and mtc0.
    applyStimulus(1, 0, 12, 32'hFFFF_FFFF, 1, 32'h0000_6000, 1, 12, 6'h3F, 0);
    applyStimulus(0, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_prio_sr", last_dout, 32'd0);
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_prio_cause", last_dout, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] a1r, a2r, excr;
      logic [4:0] exc_tab [4];
      exc_tab[0] = 5'd4; exc_tab[1] = 5'd5; exc_tab[2] = 5'd10; exc_tab[3] = 5'd12;
      a1r  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      a2r  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      excr = ($urandom_range(0, 5) == 0) ? exc_tab[$urandom_range(0, 3)] : 5'd0;
      applyStimulus(($urandom_range(0, 99) == 0), a1r, a2r, $urandom,
                    ($urandom_range(0, 3) == 0), $urandom, 1'($urandom),
                    excr, ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                    ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
